// File: rtl/led_strip_sequencer.sv
// Frame sequencer for a chain of WS2812B LEDs: snapshots the on/off request vector,
// hands one GRB word per LED to a serial driver, then holds the line idle for the latch gap.
// Optional feature: define LED_STRIP_SEQ_AUTO_REFRESH_EN to start a frame automatically
// whenever leds differs from the last transmitted snapshot.
module led_strip_sequencer #(
  parameter int unsigned CLK_FREQ = 27_000_000,
  parameter int unsigned N_LEDS   = 16,
  parameter logic [23:0] COLOR    = 24'h000f00,
  parameter int unsigned GAP_US   = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] leds,
  input  logic              start,
  input  logic              drv_busy,
  input  logic              drv_latched,
  output logic              drv_ready,
  output logic [23:0]       drv_rgb,
  output logic              frame_busy,
  output logic              frame_done
);

  localparam int unsigned GAP_CYCLES = CLK_FREQ / 1_000_000 * GAP_US;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned IW = $clog2(N_LEDS);

  localparam logic [IW-1:0] IDX_LAST    = IW'(N_LEDS - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 1);
  // Count value one before the last gap cycle; frame_done is registered, so it is
  // raised on this edge to be high during the last gap cycle itself.
  localparam logic [GW-1:0] GAP_PRELAST = GW'(GAP_CYCLES - 2);

  typedef enum logic [1:0] {StIdle, StSend, StDrain, StGap} state_t;

  state_t            state;
  logic [N_LEDS-1:0] snap;
  logic [IW-1:0]     idx;
  logic [GW-1:0]     gap_cnt;
  logic              pend;
  logic [IW-1:0]     idx_next;
  logic              go;

`ifdef LED_STRIP_SEQ_AUTO_REFRESH_EN
  logic [N_LEDS-1:0] last_snap;
`endif

  // Next LED index and the frame-start condition seen in IDLE
  always_comb begin
    idx_next = idx + IW'(1);
`ifdef LED_STRIP_SEQ_AUTO_REFRESH_EN
    go = start | pend | (leds != last_snap);
`else
    go = start | pend;
`endif
  end

  // Frame FSM with registered driver-side and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      snap       <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      pend       <= 1'b0;
      drv_ready  <= 1'b0;
      drv_rgb    <= 24'h0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
`ifdef LED_STRIP_SEQ_AUTO_REFRESH_EN
      last_snap  <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        StIdle: begin
          if (go) begin
            state      <= StSend;
            snap       <= leds;
            idx        <= '0;
            pend       <= 1'b0;
            drv_ready  <= 1'b1;
            drv_rgb    <= leds[0] ? COLOR : 24'h0;
            frame_busy <= 1'b1;
`ifdef LED_STRIP_SEQ_AUTO_REFRESH_EN
            last_snap  <= leds;
`endif
          end
        end
        StSend: begin
          if (start) pend <= 1'b1;
          if (drv_latched) begin
            if (idx == IDX_LAST) begin
              state     <= StDrain;
              drv_ready <= 1'b0;
              drv_rgb   <= 24'h0;
            end else begin
              idx     <= idx_next;
              drv_rgb <= snap[idx_next] ? COLOR : 24'h0;
            end
          end
        end
        StDrain: begin
          if (start) pend <= 1'b1;
          if (!drv_busy) begin
            state      <= StGap;
            gap_cnt    <= '0;
            frame_done <= (GAP_CYCLES == 1);
          end
        end
        StGap: begin
          if (gap_cnt == GAP_LAST) begin
            // A start arriving on this very cycle stays pending for the next frame
            pend <= start;
            if (pend) begin
              state     <= StSend;
              snap      <= leds;
              idx       <= '0;
              drv_ready <= 1'b1;
              drv_rgb   <= leds[0] ? COLOR : 24'h0;
`ifdef LED_STRIP_SEQ_AUTO_REFRESH_EN
              last_snap <= leds;
`endif
            end else begin
              state      <= StIdle;
              frame_busy <= 1'b0;
            end
          end else begin
            if (start) pend <= 1'b1;
            gap_cnt    <= gap_cnt + GW'(1);
            frame_done <= (gap_cnt == GAP_PRELAST);
          end
        end
        default: begin
          state      <= StIdle;
          frame_busy <= 1'b0;
          drv_ready  <= 1'b0;
          drv_rgb    <= 24'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_strip_sequencer.sv
// Scoreboard bench for led_strip_sequencer with a behavioural WS2812B driver model.
// Expected words are queued at stimulus time; the monitor pops one per driver latch.
module tb_led_strip_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  leds;
  logic        start;
  logic        spur_latched;
  logic        model_latched;
  logic        model_busy;
  logic        drv_busy;
  logic        drv_latched;
  logic        drv_ready;
  logic [23:0] drv_rgb;
  logic        frame_busy;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int word_no = 0;
  int since = -1;
  logic busy_q = 1'b0;
  logic drain_chk = 1'b0;
  logic [23:0] mon_w;
  logic [23:0] exp_q[$];

  assign drv_latched = model_latched | spur_latched;
  assign drv_busy    = model_busy;

  always #5 clk = ~clk;

  led_strip_sequencer #(
    .CLK_FREQ(1_000_000),
    .N_LEDS  (4),
    .COLOR   (24'h000f00),
    .GAP_US  (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .leds       (leds),
    .start      (start),
    .drv_busy   (drv_busy),
    .drv_latched(drv_latched),
    .drv_ready  (drv_ready),
    .drv_rgb    (drv_rgb),
    .frame_busy (frame_busy),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver model: latch one cycle after ready, 24-cycle word, busy 2 cycles past last word
  initial begin
    model_latched = 1'b0;
    model_busy    = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (drv_ready) begin
        @(posedge clk); #1;
        model_latched = 1'b1;
        model_busy    = 1'b1;
        @(posedge clk); #1;
        model_latched = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        if (!drv_ready) begin
          repeat (2) @(posedge clk);
          #1;
          model_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: compare latched words, post-frame drain outputs and gap length
  always @(negedge clk) begin
    if (rst) begin
      word_no   = 0;
      drain_chk = 1'b0;
    end else if (model_latched) begin
      word_no++;
      check("ready_at_latch", {31'b0, drv_ready}, 32'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h expected none", drv_rgb);
      end else begin
        mon_w = exp_q.pop_front();
        check("word", {8'b0, drv_rgb}, {8'b0, mon_w});
      end
      drain_chk = (word_no % 4 == 0);
    end else if (drain_chk) begin
      check("drain_ready", {31'b0, drv_ready}, 32'd0);
      check("drain_rgb", {8'b0, drv_rgb}, 32'd0);
      drain_chk = 1'b0;
    end
    if (busy_q && !drv_busy) since = 0;
    else if (since >= 0) since++;
    if (frame_done) begin
      done_cnt++;
      if (since >= 0) check("gap_len", since, 32'd10);
      since = -1;
    end
    busy_q = drv_busy;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_frame(input logic [3:0] p);
    for (int i = 0; i < 4; i++) exp_q.push_back(p[i] ? 24'h000f00 : 24'h000000);
  endtask

  // Returns on the negedge where frame_done is high
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 600);
    if (!frame_done) begin
      total++;
      bad++;
      $display("FAIL timeout_done: got no frame_done expected one within 600 cycles");
    end
  endtask

  task automatic wait_latch(input int k);
    int seen = 0;
    int n = 0;
    while (seen < k && n < 400) begin
      @(negedge clk);
      n++;
      if (model_latched) seen++;
    end
    if (seen < k) begin
      total++;
      bad++;
      $display("FAIL timeout_latch: got %0d latches expected %0d", seen, k);
    end
  endtask

  task automatic wait_busy_fall();
    logic p;
    int n = 0;
    logic fell = 1'b0;
    p = drv_busy;
    while (!fell && n < 400) begin
      @(negedge clk);
      n++;
      if (p && !drv_busy) fell = 1'b1;
      p = drv_busy;
    end
    if (!fell) begin
      total++;
      bad++;
      $display("FAIL timeout_busy_fall: got busy=%0b expected a falling edge", drv_busy);
    end
  endtask

  initial begin
    int bc;
    rst          = 1'b1;
    start        = 1'b0;
    leds         = 4'b0000;
    spur_latched = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, drv_ready}, 32'd0);
    check("rst_rgb", {8'b0, drv_rgb}, 32'd0);
    check("rst_busy", {31'b0, frame_busy}, 32'd0);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef LED_STRIP_SEQ_AUTO_REFRESH_EN
    repeat (20) @(negedge clk);
    check("auto_quiet", {31'b0, frame_busy}, 32'd0);
    push_frame(4'b0010);
    leds = 4'b0010;
    wait_done();
    repeat (40) @(negedge clk);
    check("auto_one_frame", done_cnt, 32'd1);
    check("auto_idle", {31'b0, frame_busy}, 32'd0);
    push_frame(4'b1000);
    leds = 4'b1000;
    wait_done();
    repeat (5) @(negedge clk);
    check("auto_two_frames", done_cnt, 32'd2);
    check("auto_q_empty", exp_q.size(), 32'd0);
`else
    // Basic frame
    leds = 4'b0101;
    push_frame(4'b0101);
    pulse_start();
    wait_done();
    @(negedge clk);
    check("a_idle_busy", {31'b0, frame_busy}, 32'd0);
    check("a_idle_ready", {31'b0, drv_ready}, 32'd0);
    check("a_done_pulse", {31'b0, frame_done}, 32'd0);
    check("a_q_empty", exp_q.size(), 32'd0);

    // leds change mid-frame does not disturb the snapshot
    push_frame(4'b0101);
    pulse_start();
    wait_latch(1);
    @(negedge clk);
    leds = 4'b1111;
    wait_done();
    repeat (20) @(negedge clk);
    check("b_done_cnt", done_cnt, 32'd2);
    check("b_idle_busy", {31'b0, frame_busy}, 32'd0);
    check("b_q_empty", exp_q.size(), 32'd0);

    // Three starts mid-frame collapse into one back-to-back frame
    leds = 4'b0101;
    push_frame(4'b0101);
    pulse_start();
    wait_latch(1);
    repeat (3) begin
      pulse_start();
      @(negedge clk);
    end
    leds = 4'b0011;
    push_frame(4'b0011);
    wait_done();
    @(negedge clk);
    check("c_no_idle_busy", {31'b0, frame_busy}, 32'd1);
    check("c_no_idle_ready", {31'b0, drv_ready}, 32'd1);
    check("c_fresh_rgb", {8'b0, drv_rgb}, 32'h000f00);
    wait_done();
    repeat (30) @(negedge clk);
    check("c_done_cnt", done_cnt, 32'd4);
    check("c_idle_busy", {31'b0, frame_busy}, 32'd0);
    check("c_q_empty", exp_q.size(), 32'd0);

    // Spurious latch pulses in IDLE and GAP
    spur_latched = 1'b1;
    @(negedge clk);
    spur_latched = 1'b0;
    check("d_idle_busy", {31'b0, frame_busy}, 32'd0);
    check("d_idle_ready", {31'b0, drv_ready}, 32'd0);
    leds = 4'b1001;
    push_frame(4'b1001);
    pulse_start();
    wait_busy_fall();
    repeat (3) @(negedge clk);
    spur_latched = 1'b1;
    @(negedge clk);
    spur_latched = 1'b0;
    wait_done();
    @(negedge clk);
    leds = 4'b0110;
    push_frame(4'b0110);
    pulse_start();
    wait_done();
    repeat (5) @(negedge clk);
    check("d_done_cnt", done_cnt, 32'd6);
    check("d_q_empty", exp_q.size(), 32'd0);

    // Reset during SEND idx=2 aborts the frame
    leds = 4'b0101;
    exp_q.push_back(24'h000f00);
    exp_q.push_back(24'h000000);
    pulse_start();
    wait_latch(2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("e_rst_ready", {31'b0, drv_ready}, 32'd0);
    check("e_rst_busy", {31'b0, frame_busy}, 32'd0);
    check("e_rst_rgb", {8'b0, drv_rgb}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bc = 0;
    repeat (50) begin
      @(negedge clk);
      if (frame_busy || frame_done || drv_ready) bc++;
    end
    check("e_stay_idle", bc, 32'd0);
    check("e_done_cnt", done_cnt, 32'd6);
    check("e_q_empty", exp_q.size(), 32'd0);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
